// File: rtl/hdc_fusion_stream_driver.sv
// hdc_fusion_stream_driver
//   On-chip traffic engine for hdc_sensor_fusion. Stores NUM_ENTRY feature
//   vectors with expected valence/arousal labels, streams the features into
//   the core (fin_valid/fin_ready), drains labels (dout_valid/dout_ready),
//   counts label mismatches and measures per-entry latency in cycles.
//   Optional build macro: HDC_DRV_RX_BACKPRESSURE_EN -- when defined,
//   dout_ready drops for gap_cycles cycles after every consumed label.
module hdc_fusion_stream_driver #(
  parameter int FEAT_W     = 64,
  parameter int NUM_ENTRY  = 20,
  parameter int ENTRY_W    = $clog2(NUM_ENTRY + 1),
  parameter int GAP_W      = 4,
  parameter int CYC_W      = 32,
  parameter int CHECK_SKIP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [FEAT_W-1:0] load_feature,
  input  logic              load_v,
  input  logic              load_a,
  input  logic              clear,
  input  logic              start,
  input  logic [GAP_W-1:0]  gap_cycles,
  output logic [FEAT_W-1:0] features_top,
  output logic              fin_valid,
  input  logic              fin_ready,
  input  logic              valence,
  input  logic              arousal,
  input  logic              dout_valid,
  output logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic [ENTRY_W:0]  num_fail,
  output logic [CYC_W-1:0]  total_latency,
  output logic [CYC_W-1:0]  max_latency,
  output logic              protocol_err
);

  localparam logic [ENTRY_W-1:0] N_L    = ENTRY_W'(NUM_ENTRY);
  localparam logic [ENTRY_W-1:0] SKIP_L = ENTRY_W'(CHECK_SKIP);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state_q;
  logic [ENTRY_W-1:0]  wr_ptr_q, tx_ptr_q, rx_ptr_q;
  logic [CYC_W-1:0]    cyc_q, total_q, max_q;
  logic [ENTRY_W:0]    num_fail_q;
  logic [GAP_W-1:0]    gap_q, txgap_q;
  logic                fin_valid_q, dout_ready_q, perr_q;
  logic [FEAT_W-1:0]   feat_q;
`ifdef HDC_DRV_RX_BACKPRESSURE_EN
  logic [GAP_W-1:0]    rxgap_q;
`endif

  logic [FEAT_W-1:0]   mem_q   [NUM_ENTRY];
  logic                exp_v_q [NUM_ENTRY];
  logic                exp_a_q [NUM_ENTRY];
  logic [CYC_W-1:0]    stamp_q [NUM_ENTRY];

  logic                full_d, ctl_idle_d, load_fire_d, start_fire_d, clear_fire_d;
  logic                fin_fire_d, dout_fire_d, rx_ok_d;
  logic [ENTRY_W-1:0]  tx_nxt_d, rx_nxt_d;
  logic [CYC_W-1:0]    lat_d;
  logic [1:0]          mism_d;

  // Latency accumulation clamps at all-ones instead of wrapping.
  function automatic logic [CYC_W-1:0] sat_add(input logic [CYC_W-1:0] a,
                                               input logic [CYC_W-1:0] b);
    logic [CYC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CYC_W] ? {CYC_W{1'b1}} : s[CYC_W-1:0];
  endfunction

  assign full_d       = (wr_ptr_q == N_L);
  assign ctl_idle_d   = (state_q != S_RUN);
  assign load_ready   = ctl_idle_d && !full_d;
  // clear has priority over a load or start in the same cycle
  assign clear_fire_d = clear && ctl_idle_d;
  assign load_fire_d  = load_valid && load_ready && !clear;
  assign start_fire_d = start && ctl_idle_d && full_d && !clear;
  assign fin_fire_d   = fin_valid_q && fin_ready;
  assign dout_fire_d  = dout_valid && dout_ready_q;
  // A label is only legal for an entry whose feature was already handed over
  assign rx_ok_d      = (rx_ptr_q < tx_ptr_q);
  assign tx_nxt_d     = tx_ptr_q + 1'b1;
  assign rx_nxt_d     = rx_ptr_q + 1'b1;
  assign lat_d        = cyc_q - stamp_q[rx_ptr_q];
  assign mism_d       = {1'b0, valence != exp_v_q[rx_ptr_q]} + {1'b0, arousal != exp_a_q[rx_ptr_q]};

  assign features_top  = feat_q;
  assign fin_valid     = fin_valid_q;
  assign dout_ready    = dout_ready_q;
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign num_fail      = num_fail_q;
  assign total_latency = total_q;
  assign max_latency   = max_q;
  assign protocol_err  = perr_q;

  // Control FSM: loading, run sequencing, TX/RX handshakes and result counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      tx_ptr_q     <= '0;
      rx_ptr_q     <= '0;
      cyc_q        <= '0;
      total_q      <= '0;
      max_q        <= '0;
      num_fail_q   <= '0;
      gap_q        <= '0;
      txgap_q      <= '0;
      fin_valid_q  <= 1'b0;
      dout_ready_q <= 1'b0;
      perr_q       <= 1'b0;
      feat_q       <= '0;
`ifdef HDC_DRV_RX_BACKPRESSURE_EN
      rxgap_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          cyc_q <= cyc_q + 1'b1;
          // TX: hold the vector until accepted, then optionally idle gap_q cycles
          if (fin_fire_d) begin
            tx_ptr_q <= tx_nxt_d;
            if (gap_q == '0 && tx_nxt_d < N_L) begin
              fin_valid_q <= 1'b1;
              feat_q      <= mem_q[tx_nxt_d];
            end else begin
              fin_valid_q <= 1'b0;
              txgap_q     <= gap_q;
            end
          end else if (!fin_valid_q && txgap_q != '0) begin
            txgap_q <= txgap_q - 1'b1;
            if (txgap_q == GAP_W'(1) && tx_ptr_q < N_L) begin
              fin_valid_q <= 1'b1;
              feat_q      <= mem_q[tx_ptr_q];
            end
          end
          // RX: score the label against the stored expectation
          if (dout_fire_d) begin
            if (!rx_ok_d) begin
              perr_q <= 1'b1;
            end else begin
              total_q <= sat_add(total_q, lat_d);
              if (lat_d > max_q) max_q <= lat_d;
              if (rx_ptr_q >= SKIP_L) num_fail_q <= num_fail_q + (ENTRY_W+1)'(mism_d);
              rx_ptr_q <= rx_nxt_d;
              if (rx_nxt_d == N_L) begin
                state_q      <= S_DONE;
                dout_ready_q <= 1'b0;
                fin_valid_q  <= 1'b0;
              end
`ifdef HDC_DRV_RX_BACKPRESSURE_EN
              else if (gap_q != '0) begin
                dout_ready_q <= 1'b0;
                rxgap_q      <= gap_q;
              end
`endif
            end
          end
`ifdef HDC_DRV_RX_BACKPRESSURE_EN
          else if (!dout_ready_q && rxgap_q != '0) begin
            rxgap_q <= rxgap_q - 1'b1;
            if (rxgap_q == GAP_W'(1)) dout_ready_q <= 1'b1;
          end
`endif
        end
        default: begin
          if (clear_fire_d) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            num_fail_q <= '0;
            total_q    <= '0;
            max_q      <= '0;
            perr_q     <= 1'b0;
          end else begin
            if (load_fire_d) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (start_fire_d) begin
              state_q      <= S_RUN;
              tx_ptr_q     <= '0;
              rx_ptr_q     <= '0;
              cyc_q        <= '0;
              num_fail_q   <= '0;
              total_q      <= '0;
              max_q        <= '0;
              perr_q       <= 1'b0;
              gap_q        <= gap_cycles;
              txgap_q      <= '0;
              fin_valid_q  <= 1'b1;
              feat_q       <= mem_q[0];
              dout_ready_q <= 1'b1;
`ifdef HDC_DRV_RX_BACKPRESSURE_EN
              rxgap_q      <= '0;
`endif
            end
          end
        end
      endcase
    end
  end

  // Entry storage and launch timestamps; pure data, never reset
  always_ff @(posedge clk) begin
    if (load_fire_d) begin
      mem_q[wr_ptr_q]   <= load_feature;
      exp_v_q[wr_ptr_q] <= load_v;
      exp_a_q[wr_ptr_q] <= load_a;
    end
    if (fin_fire_d) stamp_q[tx_ptr_q] <= cyc_q;
  end

endmodule

// File: tb/tb_hdc_fusion_stream_driver.sv
// Randomized bench for hdc_fusion_stream_driver: the bench plays the core,
// accepts features, returns labels after a chosen latency and scores the
// driver's counters against numbers derived from its own handshake log.
module tb_hdc_fusion_stream_driver;
  localparam int N  = 20;
  localparam int FW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_valid = 1'b0, load_v = 1'b0, load_a = 1'b0;
  logic          load_ready;
  logic [FW-1:0] load_feature = '0;
  logic          clear = 1'b0, start = 1'b0;
  logic [3:0]    gap_cycles = '0;
  logic [FW-1:0] features_top;
  logic          fin_valid, dout_ready, busy, done, protocol_err;
  logic          fin_ready = 1'b0, valence = 1'b0, arousal = 1'b0, dout_valid = 1'b0;
  logic [5:0]    num_fail;
  logic [31:0]   total_latency, max_latency;

  hdc_fusion_stream_driver #(.FEAT_W(FW)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_feature(load_feature), .load_v(load_v), .load_a(load_a), .clear(clear),
    .start(start), .gap_cycles(gap_cycles), .features_top(features_top),
    .fin_valid(fin_valid), .fin_ready(fin_ready), .valence(valence), .arousal(arousal),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done),
    .num_fail(num_fail), .total_latency(total_latency), .max_latency(max_latency),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  logic [FW-1:0] feat_m [N];
  logic          ev_m [N], ea_m [N], cv_m [N], ca_m [N];
  int            tx_time [N], rx_time [N];
  int            tx_idx, rx_idx;
  int            exp_fail, exp_max;
  longint        exp_total;
  int            checks = 0, failures = 0;
  bit            rand_stall = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic gen_entries();
    for (int i = 0; i < N; i++) begin
      feat_m[i] = {$urandom, $urandom};
      ev_m[i] = 1'($urandom); ea_m[i] = 1'($urandom);
      cv_m[i] = 1'b0; ca_m[i] = 1'b0;
    end
  endtask

  task automatic load_one(input int i);
    load_valid = 1'b1; load_feature = feat_m[i]; load_v = ev_m[i]; load_a = ea_m[i];
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic do_start(input int g);
    gap_cycles = 4'(g); start = 1'b1; tick(); start = 1'b0;
    tx_idx = 0; rx_idx = 0;
  endtask

  // Acts as the core: accepts features, returns each label lat cycles after its
  // feature handshake (held until taken), optional stall on one entry. Stops at
  // done, or once stop_tx features were accepted when stop_tx >= 0.
  task automatic stream(input int lat, input int stall_e, input int stall_n, input int stop_tx);
    int cyc, stall_left, e, l;
    int due_q[$], ent_q[$];
    bit fr, in_stall;
    cyc = 0; stall_left = stall_n;
    while (done !== 1'b1) begin
      if (cyc > 3000) begin
        checks++; failures++;
        $display("FAIL stream_timeout got tx=%0d rx=%0d want done=1", tx_idx, rx_idx);
        break;
      end
      fr = 1'b1;
      in_stall = (tx_idx == stall_e) && (stall_left > 0) && (fin_valid || stall_left < stall_n);
      if (in_stall) begin
        fr = 1'b0; stall_left--;
        checks++;
        if (fin_valid !== 1'b1 || features_top !== feat_m[tx_idx]) begin
          failures++;
          $display("FAIL stall_stable got valid=%b feat=%h want valid=1 feat=%h", fin_valid, features_top, feat_m[tx_idx]);
        end
      end else if (rand_stall && $urandom_range(0, 2) == 0) begin
        fr = 1'b0;
      end
      fin_ready = fr;
      if (ent_q.size() > 0 && due_q[0] <= cyc) begin
        e = ent_q[0];
        dout_valid = 1'b1; valence = ev_m[e] ^ cv_m[e]; arousal = ea_m[e] ^ ca_m[e];
      end else begin
        dout_valid = 1'b0; valence = 1'($urandom); arousal = 1'($urandom);
      end
      if (fin_valid === 1'b1 && fr) begin
        checks++;
        if (tx_idx >= N) begin
          failures++; $display("FAIL extra_fin got tx=%0d want <%0d", tx_idx, N);
        end else begin
          if (features_top !== feat_m[tx_idx]) begin
            failures++;
            $display("FAIL fin_data entry=%0d got=%h want=%h", tx_idx, features_top, feat_m[tx_idx]);
          end
          tx_time[tx_idx] = cyc; due_q.push_back(cyc + lat); ent_q.push_back(tx_idx); tx_idx++;
        end
      end
      if (dout_valid && dout_ready === 1'b1) begin
        if (rx_idx < N) rx_time[rx_idx] = cyc;
        rx_idx++;
        void'(due_q.pop_front()); void'(ent_q.pop_front());
      end
      tick(); cyc++;
      if (stop_tx >= 0 && tx_idx == stop_tx) break;
    end
    fin_ready = 1'b0; dout_valid = 1'b0;
    exp_fail = 0; exp_total = 0; exp_max = 0;
    for (int i = 0; i < rx_idx && i < N; i++) begin
      l = rx_time[i] - tx_time[i];
      exp_total += l;
      if (l > exp_max) exp_max = l;
      if (i >= 2) exp_fail += int'(cv_m[i]) + int'(ca_m[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
    checks++;
    if ({fin_valid, dout_ready, busy, done, protocol_err} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=00000", {fin_valid, dout_ready, busy, done, protocol_err});
    end
    checks++;
    if (num_fail !== 0 || total_latency !== 0 || max_latency !== 0 || features_top !== 0) begin
      failures++; $display("FAIL reset_results got nf=%0d tot=%0d max=%0d feat=%h want all 0", num_fail, total_latency, max_latency, features_top);
    end
    checks++;
    if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got=%b want=1", load_ready); end
  endtask

  task automatic test_load_limits();
    gen_entries();
    for (int i = 0; i < N - 1; i++) load_one(i);
    do_start(0);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL start_19 got busy=%b done=%b want 0 0", busy, done);
    end
    load_one(N - 1);
    checks++;
    if (load_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b want=0", load_ready); end
    load_valid = 1'b1; load_feature = {$urandom, $urandom}; tick(); load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin failures++; $display("FAIL load_21 got ready=%b want=0", load_ready); end
  endtask

  task automatic test_fixed_latency();
    do_start(0);
    stream(10, -1, 0, -1);
    checks++;
    if (done !== 1'b1 || num_fail !== 0 || total_latency !== 200 || max_latency !== 10 || protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL fixed_lat got done=%b nf=%0d tot=%0d max=%0d perr=%b want 1 0 200 10 0", done, num_fail, total_latency, max_latency, protocol_err);
    end
  endtask

  task automatic test_mismatch_stall(input string nm);
    cv_m[0] = 1; ca_m[0] = 1; cv_m[1] = 1; ca_m[1] = 1; cv_m[5] = 1; ca_m[5] = 1;
    do_start(0);
    stream(10, 3, 6, -1);
    checks++;
    if (done !== 1'b1 || num_fail !== 2 || total_latency !== 200 || max_latency !== 10 || protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL %s got done=%b nf=%0d tot=%0d max=%0d perr=%b want 1 2 200 10 0", nm, done, num_fail, total_latency, max_latency, protocol_err);
    end
    checks++;
    if (num_fail !== exp_fail) begin failures++; $display("FAIL %s_model got nf=%0d want=%0d", nm, num_fail, exp_fail); end
  endtask

  task automatic test_gap();
    for (int i = 0; i < N; i++) begin cv_m[i] = 0; ca_m[i] = 0; end
    do_start(3);
    stream(5, -1, 0, -1);
    for (int i = 1; i < N; i++) begin
      checks++;
      if (tx_time[i] - tx_time[i-1] !== 4) begin
        failures++; $display("FAIL gap_spacing entry=%0d got=%0d want=4", i, tx_time[i] - tx_time[i-1]);
      end
    end
    checks++;
    if (num_fail !== 0 || total_latency !== 100 || max_latency !== 5) begin
      failures++; $display("FAIL gap_results got nf=%0d tot=%0d max=%0d want 0 100 5", num_fail, total_latency, max_latency);
    end
  endtask

  task automatic test_protocol_err();
    do_start(0);
    fin_ready = 1'b0; dout_valid = 1'b1; valence = 1'b0; arousal = 1'b0;
    tick();
    dout_valid = 1'b0;
    checks++;
    if (protocol_err !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL perr_flag got perr=%b busy=%b want 1 1", protocol_err, busy);
    end
    stream(7, -1, 0, -1);
    checks++;
    if (rx_idx !== N || done !== 1'b1 || num_fail !== 0 || total_latency !== 140 || protocol_err !== 1'b1) begin
      failures++;
      $display("FAIL perr_run got rx=%0d done=%b nf=%0d tot=%0d perr=%b want %0d 1 0 140 1", rx_idx, done, num_fail, total_latency, protocol_err, N);
    end
  endtask

  task automatic test_random();
    int g, lat;
    for (int r = 0; r < 3; r++) begin
      do_clear();
      checks++;
      if (done !== 1'b0 || load_ready !== 1'b1 || num_fail !== 0 || total_latency !== 0 || protocol_err !== 1'b0) begin
        failures++;
        $display("FAIL clear got done=%b ready=%b nf=%0d tot=%0d perr=%b want 0 1 0 0 0", done, load_ready, num_fail, total_latency, protocol_err);
      end
      gen_entries();
      for (int i = 0; i < N; i++) begin cv_m[i] = 1'($urandom); ca_m[i] = 1'($urandom); end
      for (int i = 0; i < N; i++) load_one(i);
      g = $urandom_range(0, 3); lat = $urandom_range(1, 12);
      rand_stall = 1;
      do_start(g);
      stream(lat, -1, 0, -1);
      rand_stall = 0;
      checks++;
      if (done !== 1'b1 || rx_idx !== N || num_fail !== exp_fail || total_latency !== exp_total ||
          max_latency !== exp_max || protocol_err !== 1'b0) begin
        failures++;
        $display("FAIL random_run%0d got done=%b rx=%0d nf=%0d tot=%0d max=%0d perr=%b want 1 %0d %0d %0d %0d 0",
                 r, done, rx_idx, num_fail, total_latency, max_latency, protocol_err, N, exp_fail, exp_total, exp_max);
      end
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < N; i++) begin cv_m[i] = 1; ca_m[i] = 1; end
    do_start(0);
    stream(2, -1, 0, 7);
    rst = 1'b0;
    tick();
    checks++;
    if (fin_valid !== 1'b0 || dout_ready !== 1'b0 || busy !== 1'b0 || num_fail !== 0 ||
        total_latency !== 0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_midrun got fv=%b dr=%b busy=%b nf=%0d tot=%0d lr=%b want 0 0 0 0 0 1",
               fin_valid, dout_ready, busy, num_fail, total_latency, load_ready);
    end
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_limits();
    test_fixed_latency();
    test_mismatch_stall("mismatch");
    test_mismatch_stall("rerun");
    test_gap();
    test_protocol_err();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
